// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and over/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered 1-cycle reads.
module sync_fifo_param #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fifo_wr_en,
    input  logic [WIDTH-1:0]         fifo_wr_data,
    input  logic                     fifo_rd_en,
    output logic [WIDTH-1:0]         fifo_rd_data,
    output logic                     fifo_rd_valid,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     fifo_almost_full,
    output logic                     fifo_almost_empty,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_wr_err,
    output logic                     fifo_rd_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q, count_q, count_d;
    logic             wr_err_q, rd_err_q;
    logic             wr_acc, rd_acc;

    assign fifo_full         = (count_q == DEPTH[AW:0]);
    assign fifo_empty        = (count_q == '0);
    assign fifo_almost_full  = (count_q >= AF_THRESH[AW:0]);
    assign fifo_almost_empty = (count_q <= AE_THRESH[AW:0]);
    assign fifo_count        = count_q;
    assign fifo_wr_err       = wr_err_q;
    assign fifo_rd_err       = rd_err_q;

    assign wr_acc = fifo_wr_en & ~fifo_full;
    assign rd_acc = fifo_rd_en & ~fifo_empty;

    always_comb begin
        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_d;
            wr_err_q <= fifo_wr_en & fifo_full;
            rd_err_q <= fifo_rd_en & fifo_empty;
        end
    end

    // Storage is deliberately left uninitialised; reset only clears the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q[AW-1:0]] <= fifo_wr_data;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign fifo_rd_data  = mem[rd_ptr_q[AW-1:0]];
    assign fifo_rd_valid = ~fifo_empty;
`else
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) rd_data_q <= mem[rd_ptr_q[AW-1:0]];
        end
    end

    assign fifo_rd_data  = rd_data_q;
    assign fifo_rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: DEPTH=8 and DEPTH=16 instances share stimulus, each tracked by a
// shift-list model of stored words. Works with or without SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_param;

`ifdef SYNC_FIFO_FWFT_EN
    localparam bit Fwft = 1'b1;
`else
    localparam bit Fwft = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] wr_data = '0;

    logic [31:0] rd_data0, rd_data1;
    logic        valid0, full0, empty0, af0, ae0, werr0, rerr0;
    logic        valid1, full1, empty1, af1, ae1, werr1, rerr1;
    logic [3:0]  cnt0;
    logic [4:0]  cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.WIDTH(32), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) u_dut8 (
        .clk(clk), .rst(rst), .fifo_wr_en(wr_en), .fifo_wr_data(wr_data), .fifo_rd_en(rd_en),
        .fifo_rd_data(rd_data0), .fifo_rd_valid(valid0), .fifo_full(full0), .fifo_empty(empty0),
        .fifo_almost_full(af0), .fifo_almost_empty(ae0), .fifo_count(cnt0),
        .fifo_wr_err(werr0), .fifo_rd_err(rerr0)
    );

    sync_fifo_param #(.WIDTH(32), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4)) u_dut16 (
        .clk(clk), .rst(rst), .fifo_wr_en(wr_en), .fifo_wr_data(wr_data), .fifo_rd_en(rd_en),
        .fifo_rd_data(rd_data1), .fifo_rd_valid(valid1), .fifo_full(full1), .fifo_empty(empty1),
        .fifo_almost_full(af1), .fifo_almost_empty(ae1), .fifo_count(cnt1),
        .fifo_wr_err(werr1), .fifo_rd_err(rerr1)
    );

    // Status packed as {count[4:0], full, empty, af, ae, wr_err, rd_err, rd_valid}
    logic [11:0] act_st [2];
    logic [31:0] act_data [2];
    assign act_st[0]   = {1'b0, cnt0, full0, empty0, af0, ae0, werr0, rerr0, valid0};
    assign act_st[1]   = {cnt1, full1, empty1, af1, ae1, werr1, rerr1, valid1};
    assign act_data[0] = rd_data0;
    assign act_data[1] = rd_data1;

    // Reference model: an ordered list of stored words per instance, oldest at index 0
    int          dd [2] = '{8, 16};
    int          af [2] = '{6, 12};
    int          ae [2] = '{2, 4};
    logic [31:0] mq [2][16];
    int          mn [2] = '{0, 0};
    logic        ewerr [2] = '{1'b0, 1'b0};
    logic        ererr [2] = '{1'b0, 1'b0};
    logic        evalid [2] = '{1'b0, 1'b0};
    logic [31:0] edata [2] = '{32'h0, 32'h0};
    logic        dchk [2] = '{1'b0, 1'b0};

    function automatic logic [11:0] exp_st(input int i);
        int n;
        n = mn[i];
        return {5'(n), n == dd[i], n == 0, n >= af[i], n <= ae[i], ewerr[i], ererr[i], evalid[i]};
    endfunction

    task automatic model_edge();
        logic        wa, ra;
        logic [31:0] popped;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mn[i] = 0;
                ewerr[i] = 1'b0;
                ererr[i] = 1'b0;
                evalid[i] = 1'b0;
                if (!Fwft) edata[i] = '0;
            end else begin
                wa = wr_en && (mn[i] < dd[i]);
                ra = rd_en && (mn[i] > 0);
                ewerr[i] = wr_en && (mn[i] == dd[i]);
                ererr[i] = rd_en && (mn[i] == 0);
                popped = mq[i][0];
                if (ra) begin
                    for (int k = 0; k < 15; k++) mq[i][k] = mq[i][k+1];
                    mn[i] = mn[i] - 1;
                end
                if (wa) begin
                    mq[i][mn[i]] = wr_data;
                    mn[i] = mn[i] + 1;
                end
                if (!Fwft) begin
                    evalid[i] = ra;
                    if (ra) edata[i] = popped;
                end
            end
            if (Fwft) begin
                evalid[i] = (mn[i] > 0);
                edata[i] = mq[i][0];
                dchk[i] = evalid[i];
            end else begin
                dchk[i] = 1'b1;
            end
        end
    endtask

    task automatic cycle(input logic w, input logic [31:0] d, input logic r, input logic rs);
        wr_en = w;
        wr_data = d;
        rd_en = r;
        rst = rs;
        @(posedge clk);
        model_edge();
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            cycle(1'b0, 32'h0, 1'b0, (c == 0));
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_st[i] !== exp_st(i)) begin
                    errors++;
                    $display("FAIL reset[%0d] dut%0d status got %h want %h", c, i, act_st[i], exp_st(i));
                end
                if (dchk[i]) begin
                    checks++;
                    if (act_data[i] !== edata[i]) begin
                        errors++;
                        $display("FAIL reset_data dut%0d got %h want %h", i, act_data[i], edata[i]);
                    end
                end
            end
        end
    endtask

    // Nine writes (last one 0xFF overflows DEPTH=8), then nine reads (last underflows DEPTH=8)
    task automatic test_fill_drain();
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        for (int s = 0; s < 19; s++) begin
            if (s < 9) cycle(1'b1, (s == 8) ? 32'hFF : 32'(s), 1'b0, 1'b0);
            else if (s < 18) cycle(1'b0, 32'h0, 1'b1, 1'b0);
            else cycle(1'b0, 32'h0, 1'b0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_st[i] !== exp_st(i)) begin
                    errors++;
                    $display("FAIL fill_drain[%0d] dut%0d status got %h want %h", s, i, act_st[i], exp_st(i));
                end
                if (dchk[i]) begin
                    checks++;
                    if (act_data[i] !== edata[i]) begin
                        errors++;
                        $display("FAIL fill_drain_data[%0d] dut%0d got %h want %h", s, i, act_data[i], edata[i]);
                    end
                end
            end
        end
    endtask

    // Hold count at 3 while streaming; pointers wrap several times
    task automatic test_back_to_back();
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        for (int s = 0; s < 23; s++) begin
            cycle(1'b1, $urandom, (s >= 3), 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_st[i] !== exp_st(i)) begin
                    errors++;
                    $display("FAIL back_to_back[%0d] dut%0d status got %h want %h", s, i, act_st[i], exp_st(i));
                end
                if (dchk[i]) begin
                    checks++;
                    if (act_data[i] !== edata[i]) begin
                        errors++;
                        $display("FAIL back_to_back_data[%0d] dut%0d got %h want %h", s, i, act_data[i], edata[i]);
                    end
                end
            end
        end
    endtask

    // Both requests at empty, then fill and both requests at full
    task automatic test_simul_edges();
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        for (int s = 0; s < 21; s++) begin
            if (s == 0) cycle(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);
            else if (s == 1) cycle(1'b0, 32'h0, 1'b1, 1'b0);
            else if (s < 10) cycle(1'b1, 32'h100 + 32'(s), 1'b0, 1'b0);
            else if (s == 10) cycle(1'b1, 32'hDEAD, 1'b1, 1'b0);
            else if (s < 19) cycle(1'b1, 32'h200 + 32'(s), 1'b0, 1'b0);
            else cycle(1'b1, 32'hBEEF, 1'b1, 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_st[i] !== exp_st(i)) begin
                    errors++;
                    $display("FAIL simul_edges[%0d] dut%0d status got %h want %h", s, i, act_st[i], exp_st(i));
                end
                if (dchk[i]) begin
                    checks++;
                    if (act_data[i] !== edata[i]) begin
                        errors++;
                        $display("FAIL simul_edges_data[%0d] dut%0d got %h want %h", s, i, act_data[i], edata[i]);
                    end
                end
            end
        end
    endtask

    // Five writes, reset, then 0x11 in and out
    task automatic test_reset_mid();
        for (int s = 0; s < 9; s++) begin
            if (s < 5) cycle(1'b1, 32'h50 + 32'(s), 1'b0, 1'b0);
            else if (s == 5) cycle(1'b1, 32'h77, 1'b1, 1'b1);
            else if (s == 6) cycle(1'b1, 32'h11, 1'b0, 1'b0);
            else cycle(1'b0, 32'h0, (s == 7), 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_st[i] !== exp_st(i)) begin
                    errors++;
                    $display("FAIL reset_mid[%0d] dut%0d status got %h want %h", s, i, act_st[i], exp_st(i));
                end
                if (dchk[i]) begin
                    checks++;
                    if (act_data[i] !== edata[i]) begin
                        errors++;
                        $display("FAIL reset_mid_data[%0d] dut%0d got %h want %h", s, i, act_data[i], edata[i]);
                    end
                end
            end
        end
    endtask

    // Walk DEPTH=16 through every count so its thresholds at 12 and 4 are exercised
    task automatic test_deep_thresholds();
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        for (int s = 0; s < 34; s++) begin
            if (s < 17) cycle(1'b1, 32'hC000 + 32'(s), 1'b0, 1'b0);
            else cycle(1'b0, 32'h0, 1'b1, 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_st[i] !== exp_st(i)) begin
                    errors++;
                    $display("FAIL deep_thresh[%0d] dut%0d status got %h want %h", s, i, act_st[i], exp_st(i));
                end
                if (dchk[i]) begin
                    checks++;
                    if (act_data[i] !== edata[i]) begin
                        errors++;
                        $display("FAIL deep_thresh_data[%0d] dut%0d got %h want %h", s, i, act_data[i], edata[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic w, r, rs;
        for (int s = 0; s < 400; s++) begin
            w  = ($urandom_range(0, 99) < ((s / 100) % 2 == 0 ? 70 : 35));
            r  = ($urandom_range(0, 99) < ((s / 100) % 2 == 0 ? 35 : 70));
            rs = ($urandom_range(0, 79) == 0);
            cycle(w, $urandom, r, rs);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_st[i] !== exp_st(i)) begin
                    errors++;
                    $display("FAIL random[%0d] dut%0d status got %h want %h", s, i, act_st[i], exp_st(i));
                end
                if (dchk[i]) begin
                    checks++;
                    if (act_data[i] !== edata[i]) begin
                        errors++;
                        $display("FAIL random_data[%0d] dut%0d got %h want %h", s, i, act_data[i], edata[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_simul_edges();
        test_reset_mid();
        test_deep_thresholds();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
